hmmm_core: RTL and testbench



---
 rtl/hmmm_pkg.sv | 35 +++
 rtl/hmmm_regfile.sv | 36 +++
 rtl/hmmm_core.sv | 176 +++++++++++++++++
 tb/tb_hmmm_core.sv | 614 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_pkg.sv
// Shared types for the hmmm_core processor: opcode and FSM state enums plus a
// register-address width helper.
package hmmm_pkg;

    typedef enum logic [3:0] {
        OP_HALT      = 4'h0,
        OP_SETN      = 4'h1,
        OP_STORER    = 4'h2,
        OP_LOADR     = 4'h3,
        OP_COPY      = 4'h4,
        OP_NEG       = 4'h5,
        OP_ADD       = 4'h6,
        OP_SUB       = 4'h7,
        OP_JEQZN     = 4'h8,
        OP_JNEZN     = 4'h9,
        OP_JGTZN     = 4'hA,
        OP_JLTZN     = 4'hB,
        OP_JUMPN     = 4'hC,
        OP_JUMPN_ALT = 4'hD,
        OP_JUMPR     = 4'hE,
        OP_JUMPR_ALT = 4'hF
    } funct_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        HALT  = 2'd3
    } state_t;

    function automatic int raw_bits(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// NREGS x WIDTH register file: two combinational read ports, one write port
// committed at the clock edge, cleared by asynchronous reset.
module hmmm_regfile
    import hmmm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int RAW  = raw_bits(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [RAW-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [RAW-1:0]   raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic [RAW-1:0]   raddr1,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata0 = regs[raddr0];
    assign rdata1 = regs[raddr1];

endmodule

// File: rtl/hmmm_core.sv
// Multicycle HMMM core with req/ack instruction and data ports and a HALT state.
// Optional macro HMMM_CORE_RETIRE_CNT_EN adds a saturating 32-bit retired-instruction count.
module hmmm_core
    import hmmm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int RAW  = raw_bits(NREGS),
    localparam int IW   = 4 + RAW + WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [IW-1:0]    imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic             halted
`ifdef HMMM_CORE_RETIRE_CNT_EN
    ,
    output logic [31:0]      retired
`endif
);

    state_t           state;
    logic [IW-1:0]    instr;
    funct_t           funct;
    logic [RAW-1:0]   ra_f, rb_f, rc_f;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] rb_v, rd1_v;
    logic             rf_we;
    logic [WIDTH-1:0] rf_wdata;
    logic             take;
    logic [WIDTH-1:0] target;
    logic             is_rrr;

    assign funct     = funct_t'(instr[IW-1 -: 4]);
    assign ra_f      = instr[IW-5 -: RAW];
    assign imm       = instr[WIDTH-1:0];
    assign rb_f      = imm[WIDTH-1 -: RAW];
    assign rc_f      = imm[WIDTH-1-RAW -: RAW];
    assign imem_addr = pc;

    // Port 1 reads rc for add/sub and ra for everything else (branches, stores).
    assign is_rrr = (funct == OP_ADD) || (funct == OP_SUB);

    hmmm_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (ra_f),
        .wdata  (rf_wdata),
        .raddr0 (rb_f),
        .rdata0 (rb_v),
        .raddr1 (is_rrr ? rc_f : ra_f),
        .rdata1 (rd1_v)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_wdata = '0;
        case (funct)
            OP_SETN: rf_wdata = imm;
            OP_COPY: rf_wdata = rb_v;
            OP_NEG:  rf_wdata = '0 - rb_v;
            OP_ADD:  rf_wdata = rb_v + rd1_v;
            OP_SUB:  rf_wdata = rb_v - rd1_v;
            default: rf_wdata = dmem_rdata;
        endcase
        if (state == EXEC) begin
            rf_we = (funct == OP_SETN) || (funct == OP_COPY) || (funct == OP_NEG) || is_rrr;
        end else if (state == MEM) begin
            rf_we = dmem_req && dmem_ack && !dmem_we;
        end
    end

    always_comb begin
        take   = 1'b0;
        target = imm;
        case (funct)
            OP_JEQZN:                  take = (rd1_v == '0);
            OP_JNEZN:                  take = (rd1_v != '0);
            OP_JGTZN:                  take = !rd1_v[WIDTH-1] && (rd1_v != '0);
            OP_JLTZN:                  take = rd1_v[WIDTH-1];
            OP_JUMPN, OP_JUMPN_ALT:    take = 1'b1;
            OP_JUMPR, OP_JUMPR_ALT: begin
                take   = 1'b1;
                target = rd1_v;
            end
            default:                   take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= '0;
            instr      <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    case (funct)
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        OP_STORER, OP_LOADR: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (funct == OP_STORER);
                            dmem_addr  <= rb_v;
                            dmem_wdata <= rd1_v;
                            state      <= MEM;
                        end
                        default: begin
                            pc       <= take ? target : pc + 1'b1;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    endcase
                end
                MEM: begin
                    // Address, data and direction stay frozen until the memory acks.
                    if (dmem_req && dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc + 1'b1;
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef HMMM_CORE_RETIRE_CNT_EN
    logic retire_evt;

    assign retire_evt = ((state == EXEC) && (funct != OP_HALT) && (funct != OP_STORER)
                         && (funct != OP_LOADR))
                        || ((state == MEM) && dmem_req && dmem_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired <= '0;
        end else if (retire_evt && (retired != '1)) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hmmm_core.sv
// Self-checking bench for hmmm_core: memory responders with random stalls and an
// ISA-level reference interpreter; a second instance covers WIDTH=12, NREGS=16.
module tb_hmmm_core;

    localparam int W   = 8;
    localparam int NR  = 8;
    localparam int IW  = 15;
    localparam int W2  = 12;
    localparam int NR2 = 16;
    localparam int IW2 = 20;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
    logic [W-1:0]  imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [IW-1:0] imem_rdata;
`ifdef HMMM_CORE_RETIRE_CNT_EN
    logic [31:0]   retired;
`endif

    logic           imem_req2, imem_ack2, dmem_req2, dmem_we2, dmem_ack2, halted2;
    logic [W2-1:0]  imem_addr2, dmem_addr2, dmem_wdata2, dmem_rdata2, pc2;
    logic [IW2-1:0] imem_rdata2;
`ifdef HMMM_CORE_RETIRE_CNT_EN
    logic [31:0]    retired2;
`endif

    hmmm_core #(.WIDTH(W), .NREGS(NR)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc(pc), .halted(halted)
`ifdef HMMM_CORE_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    hmmm_core #(.WIDTH(W2), .NREGS(NR2)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_addr(dmem_addr2), .dmem_wdata(dmem_wdata2),
        .dmem_ack(dmem_ack2), .dmem_rdata(dmem_rdata2), .pc(pc2), .halted(halted2)
`ifdef HMMM_CORE_RETIRE_CNT_EN
        , .retired(retired2)
`endif
    );

    logic [IW-1:0]  imem [256];
    logic [W-1:0]   dmem [256];
    logic [W-1:0]   dmem_init [256];
    logic [IW2-1:0] imem2 [256];

    logic [W-1:0] st_addr_q[$], st_data_q[$], fetch_q[$];
    logic [W-1:0] exp_q[$], exp_addr_q[$], exp_fetch_q[$];
    logic [W-1:0] m_regs [NR];
    logic [W-1:0] m_mem [256];
    logic [W-1:0] m_pc;
    bit           m_halted;

    int i_lat_max = 0, d_lat_max = 0, i_wait = 0, d_wait = 0;
    bit d_fixed = 1'b0, force_dack = 1'b0;
    int checks = 0, failures = 0;

    // ---------------- memory responders ----------------
    initial begin
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (reset) begin
                i_wait = $urandom_range(0, i_lat_max);
            end else if (imem_req) begin
                if (i_wait == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem[imem_addr];
                    fetch_q.push_back(imem_addr);
                    i_wait = $urandom_range(0, i_lat_max);
                end else begin
                    i_wait--;
                end
            end
        end
    end

    initial begin
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (reset) begin
                d_wait = d_fixed ? d_lat_max : $urandom_range(0, d_lat_max);
                if (force_dack) dmem_ack = 1'b1;
            end else if (dmem_req) begin
                if (d_wait == 0) begin
                    dmem_ack = 1'b1;
                    if (dmem_we) begin
                        dmem[dmem_addr] = dmem_wdata;
                        st_addr_q.push_back(dmem_addr);
                        st_data_q.push_back(dmem_wdata);
                    end else begin
                        dmem_rdata = dmem[dmem_addr];
                    end
                    d_wait = d_fixed ? d_lat_max : $urandom_range(0, d_lat_max);
                end else begin
                    d_wait--;
                end
            end
        end
    end

    initial begin
        imem_ack2 = 1'b0;
        imem_rdata2 = '0;
        dmem_ack2 = 1'b0;
        dmem_rdata2 = '0;
        forever begin
            @(negedge clk);
            imem_ack2   = imem_req2 && !reset;
            imem_rdata2 = imem2[imem_addr2[7:0]];
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [IW-1:0] enc(input logic [3:0] f, input logic [2:0] a,
                                          input logic [7:0] imm);
        return {f, a, imm};
    endfunction

    function automatic logic [7:0] rr(input logic [2:0] b, input logic [2:0] c);
        return {b, c, 2'b00};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            imem[i] = '0;
            dmem_init[i] = 8'($urandom);
            dmem[i] = dmem_init[i];
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        st_addr_q.delete();
        st_data_q.delete();
        fetch_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output bit ok);
        apply_reset();
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Instruction-set interpreter working from the encoded program in imem.
    task automatic model_run();
        logic [IW-1:0] ins;
        logic [3:0] f;
        logic [2:0] a, b, c;
        logic [7:0] imm;
        int sv;
        bit take;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = dmem_init[i];
        m_pc = '0;
        m_halted = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        exp_fetch_q.delete();
        for (int step = 0; step < 1000; step++) begin
            exp_fetch_q.push_back(m_pc);
            ins = imem[m_pc];
            f = ins[14:11];
            a = ins[10:8];
            imm = ins[7:0];
            b = imm[7:5];
            c = imm[4:2];
            sv = (m_regs[a] >= 128) ? int'(m_regs[a]) - 256 : int'(m_regs[a]);
            take = 1'b0;
            if (f == 4'd0) begin
                m_halted = 1'b1;
                break;
            end
            case (f)
                4'd1: m_regs[a] = imm;
                4'd2: begin
                    m_mem[m_regs[b]] = m_regs[a];
                    exp_addr_q.push_back(m_regs[b]);
                    exp_q.push_back(m_regs[a]);
                end
                4'd3: m_regs[a] = m_mem[m_regs[b]];
                4'd4: m_regs[a] = m_regs[b];
                4'd5: m_regs[a] = 8'(256 - int'(m_regs[b]));
                4'd6: m_regs[a] = 8'(int'(m_regs[b]) + int'(m_regs[c]));
                4'd7: m_regs[a] = 8'(int'(m_regs[b]) - int'(m_regs[c]));
                4'd8: take = (sv == 0);
                4'd9: take = (sv != 0);
                4'd10: take = (sv > 0);
                4'd11: take = (sv < 0);
                default: take = 1'b1;
            endcase
            if (take) m_pc = (f >= 4'd14) ? m_regs[a] : imm;
            else m_pc = 8'(int'(m_pc) + 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({pc, halted, imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs pc=%h halted=%b ireq=%b dreq=%b we=%b addr=%h wdata=%h required all zero",
                     pc, halted, imem_req, dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_ireq got=%b required=0", imem_req);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL release_ireq_before_edge got=%b required=0", imem_req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL first_fetch_req got=%b required=1", imem_req);
        end
    endtask

    task automatic test_sub_halt();
        bit ok, late;
        clear_prog();
        i_lat_max = 0;
        d_lat_max = 0;
        d_fixed = 1'b0;
        imem[0] = enc(4'h1, 3'd1, 8'd5);
        imem[1] = enc(4'h1, 3'd2, 8'd3);
        imem[2] = enc(4'h7, 3'd3, rr(3'd1, 3'd2));
        imem[3] = enc(4'h0, 3'd0, 8'd0);
        model_run();
        run_to_halt(200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL sub_halt_timeout halted=%b required=1", halted);
        end
        checks++;
        if (dut.u_rf.regs[3] !== m_regs[3] || m_regs[3] !== 8'd2) begin
            failures++;
            $display("FAIL sub_r3 got=%h required=%h", dut.u_rf.regs[3], 8'd2);
        end
        checks++;
        if (pc !== 8'd3) begin
            failures++;
            $display("FAIL sub_halt_pc got=%h required=03", pc);
        end
        late = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (imem_req !== 1'b0 || dmem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'd3) late = 1'b1;
        end
        checks++;
        if (late) begin
            failures++;
            $display("FAIL halt_quiet ireq=%b dreq=%b halted=%b pc=%h required 0 0 1 03",
                     imem_req, dmem_req, halted, pc);
        end
    endtask

    task automatic test_add_wrap();
        bit ok;
        clear_prog();
        i_lat_max = 2;
        imem[0] = enc(4'h1, 3'd1, 8'hFF);
        imem[1] = enc(4'h1, 3'd2, 8'h02);
        imem[2] = enc(4'h6, 3'd3, rr(3'd1, 3'd2));
        imem[3] = enc(4'h5, 3'd6, rr(3'd2, 3'd0));
        model_run();
        run_to_halt(200, ok);
        checks++;
        if (!ok || dut.u_rf.regs[3] !== 8'h01) begin
            failures++;
            $display("FAIL add_wrap r3 got=%h required=01 (halted=%b)", dut.u_rf.regs[3], halted);
        end
        checks++;
        if (dut.u_rf.regs[6] !== m_regs[6]) begin
            failures++;
            $display("FAIL neg r6 got=%h required=%h", dut.u_rf.regs[6], m_regs[6]);
        end
    endtask

    task automatic test_mem_stall();
        bit in_acc, we0;
        logic [W-1:0] a0, w0;
        int n, acc;
        clear_prog();
        i_lat_max = 1;
        d_fixed = 1'b1;
        d_lat_max = 5;
        imem[0] = enc(4'h1, 3'd1, 8'h5A);
        imem[1] = enc(4'h1, 3'd2, 8'h10);
        imem[2] = enc(4'h2, 3'd1, rr(3'd2, 3'd0));
        imem[3] = enc(4'h3, 3'd4, rr(3'd2, 3'd0));
        model_run();
        apply_reset();
        in_acc = 1'b0;
        acc = 0;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (dmem_req) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    a0 = dmem_addr;
                    w0 = dmem_wdata;
                    we0 = dmem_we;
                    n = 1;
                    checks++;
                    if (a0 !== 8'h10 || we0 !== (acc == 0) || (acc == 0 && w0 !== 8'h5A)) begin
                        failures++;
                        $display("FAIL mem_access%0d addr=%h we=%b wdata=%h required addr=10 we=%b wdata=5A",
                                 acc, a0, we0, w0, acc == 0);
                    end
                end else begin
                    n++;
                    checks++;
                    if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) begin
                        failures++;
                        $display("FAIL mem_stable addr=%h wdata=%h we=%b required %h %h %b",
                                 dmem_addr, dmem_wdata, dmem_we, a0, w0, we0);
                    end
                end
            end else if (in_acc) begin
                in_acc = 1'b0;
                checks++;
                if (n != d_lat_max + 1) begin
                    failures++;
                    $display("FAIL mem_req_cycles got=%0d required=%0d", n, d_lat_max + 1);
                end
                acc++;
            end
            if (halted) break;
        end
        checks++;
        if (!halted || acc != 2) begin
            failures++;
            $display("FAIL mem_stall_done halted=%b accesses=%0d required 1 and 2", halted, acc);
        end
        checks++;
        if (dut.u_rf.regs[4] !== m_regs[1] || pc !== m_pc) begin
            failures++;
            $display("FAIL load_r4 got=%h pc=%h required=%h pc=%h", dut.u_rf.regs[4], pc, m_regs[1], m_pc);
        end
        d_fixed = 1'b0;
        d_lat_max = 0;
    endtask

    task automatic test_branch();
        bit ok;
        clear_prog();
        i_lat_max = 1;
        imem[0]    = enc(4'h1, 3'd1, 8'h80);
        imem[1]    = enc(4'hB, 3'd1, 8'd10);
        imem[10]   = enc(4'h1, 3'd2, 8'h00);
        imem[11]   = enc(4'hA, 3'd2, 8'd30);
        imem[12]   = enc(4'h1, 3'd3, 8'h40);
        imem[13]   = enc(4'hE, 3'd3, 8'h00);
        imem[8'h40] = enc(4'h1, 3'd5, 8'h07);
        model_run();
        run_to_halt(300, ok);
        checks++;
        if (!ok || pc !== 8'h41) begin
            failures++;
            $display("FAIL branch_final_pc got=%h halted=%b required=41", pc, halted);
        end
        checks++;
        if (fetch_q.size() != exp_fetch_q.size()) begin
            failures++;
            $display("FAIL branch_trace_len got=%0d required=%0d", fetch_q.size(), exp_fetch_q.size());
        end else begin
            for (int i = 0; i < fetch_q.size(); i++) begin
                checks++;
                if (fetch_q[i] !== exp_fetch_q[i]) begin
                    failures++;
                    $display("FAIL branch_trace[%0d] got=%h required=%h", i, fetch_q[i], exp_fetch_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        bit seen, nz;
        clear_prog();
        i_lat_max = 0;
        d_fixed = 1'b1;
        d_lat_max = 30;
        imem[0] = enc(4'h1, 3'd1, 8'd9);
        imem[1] = enc(4'h1, 3'd2, 8'h20);
        imem[2] = enc(4'h2, 3'd1, rr(3'd2, 3'd0));
        apply_reset();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (dmem_req) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_mem_reach dreq=%b required=1", dmem_req);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        force_dack = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || dmem_we !== 1'b0) begin
            failures++;
            $display("FAIL async_req_drop dreq=%b ireq=%b we=%b required 0 0 0", dmem_req, imem_req, dmem_we);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        nz = 1'b0;
        for (int i = 0; i < NR; i++) if (dut.u_rf.regs[i] !== '0) nz = 1'b1;
        checks++;
        if (pc !== '0 || nz || dmem_req !== 1'b0 || st_addr_q.size() != 0) begin
            failures++;
            $display("FAIL reset_in_mem pc=%h regs_nonzero=%b dreq=%b stores=%0d required 00 0 0 0",
                     pc, nz, dmem_req, st_addr_q.size());
        end
        #2;
        force_dack = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== '0) begin
            failures++;
            $display("FAIL post_reset_idle ireq=%b pc=%h required 0 00", imem_req, pc);
        end
        @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_first_req got=%b required=1", imem_req);
        end
        d_fixed = 1'b0;
        d_lat_max = 0;
    endtask

    task automatic test_wide();
        bit ok;
        for (int i = 0; i < 256; i++) imem2[i] = '0;
        imem2[0] = {4'h1, 4'd15, 12'hABC};
        imem2[1] = {4'h4, 4'd14, 4'd15, 8'h00};
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (halted2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || pc2 !== 12'd2) begin
            failures++;
            $display("FAIL wide_halt halted=%b pc=%h required 1 002", halted2, pc2);
        end
        checks++;
        if (dut2.u_rf.regs[15] !== 12'hABC || dut2.u_rf.regs[14] !== 12'hABC) begin
            failures++;
            $display("FAIL wide_r15_r14 got=%h %h required=abc abc", dut2.u_rf.regs[15], dut2.u_rf.regs[14]);
        end
    endtask

    task automatic test_random();
        bit ok;
        int op;
        logic [3:0] bf;
        for (int iter = 0; iter < 10; iter++) begin
            clear_prog();
            i_lat_max = $urandom_range(0, 3);
            d_lat_max = $urandom_range(0, 3);
            d_fixed = 1'b0;
            for (int p = 0; p < 20; p++) begin
                op = $urandom_range(0, 9);
                case (op)
                    0, 9: imem[p] = enc(4'h1, 3'($urandom), 8'($urandom));
                    1: imem[p] = enc(4'h2, 3'($urandom), 8'($urandom));
                    2: imem[p] = enc(4'h3, 3'($urandom), 8'($urandom));
                    3: imem[p] = enc(4'h4, 3'($urandom), 8'($urandom));
                    4: imem[p] = enc(4'h5, 3'($urandom), 8'($urandom));
                    5: imem[p] = enc(4'h6, 3'($urandom), 8'($urandom));
                    6: imem[p] = enc(4'h7, 3'($urandom), 8'($urandom));
                    7: begin
                        bf = 4'(8 + $urandom_range(0, 3));
                        imem[p] = enc(bf, 3'($urandom), 8'($urandom_range(p + 1, 24)));
                    end
                    default: imem[p] = enc(4'($urandom_range(12, 13)), 3'($urandom),
                                           8'($urandom_range(p + 1, 24)));
                endcase
            end
            model_run();
            run_to_halt(2000, ok);
            checks++;
            if (!ok || pc !== m_pc) begin
                failures++;
                $display("FAIL rand%0d_pc got=%h halted=%b required=%h", iter, pc, halted, m_pc);
            end
            for (int i = 0; i < NR; i++) begin
                checks++;
                if (dut.u_rf.regs[i] !== m_regs[i]) begin
                    failures++;
                    $display("FAIL rand%0d_r%0d got=%h required=%h", iter, i, dut.u_rf.regs[i], m_regs[i]);
                end
            end
            checks++;
            if (st_data_q.size() != exp_q.size() || fetch_q.size() != exp_fetch_q.size()) begin
                failures++;
                $display("FAIL rand%0d_counts stores=%0d fetches=%0d required %0d %0d", iter,
                         st_data_q.size(), fetch_q.size(), exp_q.size(), exp_fetch_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (st_addr_q[i] !== exp_addr_q[i] || st_data_q[i] !== exp_q[i]) begin
                        failures++;
                        $display("FAIL rand%0d_store%0d got=%h@%h required=%h@%h", iter, i,
                                 st_data_q[i], st_addr_q[i], exp_q[i], exp_addr_q[i]);
                    end
                end
            end
        end
    endtask

`ifdef HMMM_CORE_RETIRE_CNT_EN
    task automatic test_retire();
        bit ok;
        clear_prog();
        i_lat_max = 1;
        d_lat_max = 2;
        imem[0] = enc(4'h1, 3'd1, 8'd1);
        imem[1] = enc(4'h1, 3'd2, 8'd2);
        imem[2] = enc(4'h6, 3'd3, rr(3'd1, 3'd2));
        imem[3] = enc(4'h2, 3'd3, rr(3'd1, 3'd0));
        run_to_halt(300, ok);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (!ok || retired !== 32'd4) begin
            failures++;
            $display("FAIL retired got=%0d halted=%b required=4", retired, halted);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) imem2[i] = '0;
        clear_prog();
        test_reset();
        test_sub_halt();
        test_add_wrap();
        test_mem_stall();
        test_branch();
        test_reset_mid_mem();
        test_wide();
        test_random();
`ifdef HMMM_CORE_RETIRE_CNT_EN
        test_retire();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
